nibble_serial_subtractor: RTL and testbench

Sequential controller that computes a WIDTH-bit subtraction diff = a − b − bin by time-multiplexing a single 4-bit ripple-borrow subtractor slice over the operand nibbles, least-significant nibble first. The borrow is carried between cycles in a register. It sits between a requester that issues one subtraction at a time and the 4-bit full-subtractor datapath, trading latency for area in wide-operand arithmetic.

---
 rtl/nibble_serial_subtractor.sv | 123 ++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// Serial WIDTH-bit subtractor: one 4-bit ripple-borrow slice is reused over
// the operand nibbles, least-significant nibble first, with the borrow kept
// in a register between cycles. One operation in flight at a time.
module nibble_serial_subtractor #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   bin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   diff,
    output logic                   bout
);

    localparam int unsigned WIDTH = 4 * NIBBLES;
    localparam int unsigned IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic [3:0]       op_a;
    logic [3:0]       op_b;
    logic [3:0]       slice_diff;
    logic             slice_bout;

    // 4-bit ripple-borrow slice on the nibble currently selected by idx
    always_comb begin
        logic c;
        c          = borrow_q;
        slice_diff = '0;
        op_a       = a_q[{idx_q, 2'b00} +: 4];
        op_b       = b_q[{idx_q, 2'b00} +: 4];
        for (int i = 0; i < 4; i++) begin
            slice_diff[i] = op_a[i] ^ op_b[i] ^ c;
            c             = (~op_a[i] & (op_b[i] ^ c)) | (op_b[i] & c);
        end
        slice_bout = c;
    end

    // Next-state logic for the controller and the datapath registers
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        idx_d    = idx_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    diff_d   = '0;
                    bout_d   = 1'b0;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                diff_d[{idx_q, 2'b00} +: 4] = slice_diff;
                borrow_d = slice_bout;
                if (idx_q == LAST_IDX) begin
                    // Top nibble: publish the final borrow; idx wraps back to 0
                    bout_d  = slice_bout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                // start is deliberately not looked at here
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            idx_q    <= idx_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor (NIBBLES=4 main instance,
// plus a small NIBBLES=1 instance for the single-slice case).
module tb_nibble_serial_subtractor;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    logic         s_start;
    logic [3:0]   s_a;
    logic [3:0]   s_b;
    logic         s_bin;
    logic         s_busy;
    logic         s_done;
    logic [3:0]   s_diff;
    logic         s_bout;

    nibble_serial_subtractor #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    nibble_serial_subtractor #(.NIBBLES(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (s_start),
        .a     (s_a),
        .b     (s_b),
        .bin   (s_bin),
        .busy  (s_busy),
        .done  (s_done),
        .diff  (s_diff),
        .bout  (s_bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [W-1:0] last_diff;
    logic         last_bout;

    always @(posedge clk) cyc = cyc + 1;

    // Reference: plain modular arithmetic; done expected N edges after acceptance
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input int at);
        exp_t e;
        int   xi;
        int   yi;
        xi     = int'(x);
        yi     = int'(y) + int'(c);
        e.diff = W'(xi - yi);
        e.bout = (xi < yi);
        e.cyc  = at + N;
        return e;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: diff %h bout %b with no pending request",
                         diff, bout);
            end else begin
                e = sb.pop_front();
                chk("diff", diff, e.diff);
                chk("bout", W'(bout), W'(e.bout));
                chk_int("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic accept_push(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t e;
        e = model(x, y, c, cyc);
        sb.push_back(e);
        last_diff = e.diff;
        last_bout = e.bout;
    endtask

    // One operation with a 1-cycle start; optionally pokes start while busy
    // and during the DONE cycle, both of which must be ignored.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input bit poke);
        start = 1'b1;
        a     = x;
        b     = y;
        bin   = c;
        @(posedge clk);
        #1;
        accept_push(x, y, c);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
        chk("busy_after_accept", W'(busy), W'(1));
        chk("diff_cleared", diff, '0);
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            #1;
            chk("busy_run", W'(busy), W'(1));
            if (poke && k == 2) begin
                start = 1'b1;
                a     = '1;
                b     = '0;
            end
            if (poke && k == 3) start = 1'b0;
            if (poke && k == N) begin
                start = 1'b1;
                a     = '1;
                b     = '0;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_fall", W'(busy), W'(0));
        chk("diff_hold", diff, last_diff);
        chk("bout_hold", W'(bout), W'(last_bout));
        @(negedge clk);
    endtask

    // start held high across two requests: second accepted N+2 edges later
    task automatic held(input logic [W-1:0] x1, input logic [W-1:0] y1,
                        input logic [W-1:0] x2, input logic [W-1:0] y2);
        start = 1'b1;
        a     = x1;
        b     = y1;
        bin   = 1'b0;
        @(posedge clk);
        #1;
        accept_push(x1, y1, 1'b0);
        a = x2;
        b = y2;
        repeat (N + 1) @(posedge clk);
        #1;
        chk("held_idle_gap", W'(busy), W'(0));
        @(posedge clk);
        #1;
        accept_push(x2, y2, 1'b0);
        start = 1'b0;
        chk("held_reaccept", W'(busy), W'(1));
        repeat (N + 1) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        bin     = 1'b0;
        s_start = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_bin   = 1'b0;
        last_diff = '0;
        last_bout = 1'b0;

        // Asynchronous reset, observed before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_diff", diff, '0);
        chk("rst_bout", W'(bout), W'(0));
        chk("rst1_diff", W'(s_diff), W'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(16'h1234, 16'h0234, 1'b0, 1'b0);
        issue(16'h0000, 16'h0001, 1'b0, 1'b0);
        issue(16'h8000, 16'h7FFF, 1'b1, 1'b0);
        issue(16'h0005, 16'h0003, 1'b0, 1'b1);
        held(16'h00F0, 16'h0F00, 16'hABCD, 16'h1234);

        // Reset after nibble 1 has been written: no done, everything cleared
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h2222;
        bin   = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_done", W'(done), W'(0));
        chk("abort_diff", diff, '0);
        chk("abort_bout", W'(bout), W'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_diff = '0;
        last_bout = 1'b0;
        @(negedge clk);
        issue(16'h0010, 16'h0001, 1'b0, 1'b0);

        // Single-slice instance: done 1 edge after acceptance... observed as
        // the cycle following E1
        s_start = 1'b1;
        s_a     = 4'h3;
        s_b     = 4'h5;
        s_bin   = 1'b0;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        chk("n1_done_early", W'(s_done), W'(0));
        chk("n1_busy", W'(s_busy), W'(1));
        @(posedge clk);
        #1;
        chk("n1_done", W'(s_done), W'(1));
        chk("n1_diff", W'(s_diff), W'(4'hE));
        chk("n1_bout", W'(s_bout), W'(1));
        @(posedge clk);
        #1;
        chk("n1_done_fall", W'(s_done), W'(0));
        chk("n1_busy_fall", W'(s_busy), W'(0));
        @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        // Edge operands
        issue('1, '1, 1'b1, 1'b0);
        issue('0, '1, 1'b1, 1'b0);
        issue('1, '0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("idle_diff_hold", diff, last_diff);
        chk("idle_bout_hold", W'(bout), W'(last_bout));
        chk_int("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
